reg_file: RTL
=============

# reg_file

Eight-entry, 8-bit, two-read/one-write register file feeding the ALU operand inputs (OUT1 → DATA1, OUT2 → DATA2) and accepting the ALU RESULT back on IN. It sits directly upstream of the ALU in the single-cycle datapath. It adds a sequenced clear after reset: registers are zeroed one per cycle while BUSY is asserted, so the control unit can stall instruction issue until the file is clean.

## Interface
Parameters:
- WIDTH, 8, data width of each register and of IN/OUT1/OUT2
- NUM_REGS, 8, register count (power of two, ≥2)
- ADDR_W, 3, address width, equal to log2(NUM_REGS)
- BYPASS, 0, 1 means a same-cycle write is forwarded to the read ports

Ports:
- CLK  input  1  single clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- IN  input  WIDTH  write data (ALU RESULT)
- INADDRESS  input  ADDR_W  write address
- WRITE  input  1  write enable
- OUT1ADDRESS  input  ADDR_W  read port 1 address
- OUT2ADDRESS  input  ADDR_W  read port 2 address
- OUT1  output  WIDTH  read port 1 data → ALU DATA1
- OUT2  output  WIDTH  read port 2 data → ALU DATA2
- BUSY  output  1  clear sequence in progress; writes ignored, reads forced to 0

## Operation
- FSM states: CLEAR, READY. Clear pointer ptr is ADDR_W bits wide.
- RESET=1 at an edge: state←CLEAR, ptr←0. No register changes while RESET is held.
- CLEAR with RESET=0: each edge sets reg[ptr]←0 and ptr←ptr+1. On the edge that clears reg[NUM_REGS-1]: state←READY and ptr wraps to 0.
- READY: at each edge with WRITE=1, reg[INADDRESS]←IN. With WRITE=0, no change.
- Reads are combinational. OUT1=reg[OUT1ADDRESS] and OUT2=reg[OUT2ADDRESS] in READY. Both outputs are 0 in CLEAR.
- BYPASS=1: if WRITE=1 in READY and a read address equals INADDRESS, that port shows IN in the same cycle. BYPASS=0: that port shows the old value until the edge.
- Both read ports may address the same register. They may also equal INADDRESS. No other conflicts exist.
- WRITE during CLEAR is dropped silently. It is not queued.
- RESET asserted mid-clear: the sequence restarts with ptr←0. Registers already cleared stay 0.
- No register is hardwired. Register 0 is writable.

## Timing
- Reset values, valid from the first RESET edge: BUSY=1, OUT1=OUT2=0, state=CLEAR, ptr=0. Register contents are undefined until cleared. Before the first reset edge, all state is undefined.
- BUSY stays high for exactly NUM_REGS rising edges after RESET deasserts (8 by default). It drops after the last clear edge.
- Write latency is 1 edge. Data written at edge n is readable from the cycle after edge n (BYPASS=0), or during the cycle of edge n (BYPASS=1).
- Read latency is 0 cycles (combinational from address to data).
- Simultaneous RESET and WRITE at an edge: RESET wins and the write is lost.

## Structure
- Package reg_file_pkg holds:
  - the state enum {CLEAR, READY};
  - default WIDTH/NUM_REGS constants;
  - the opcode-independent widths shared with the ALU (operand width 8).
- A single module is sufficient. The clear sequencer stays inline; it is too small to justify a separate sub-module.
- The ALU is instantiated alongside, not inside, this block.

## Test plan
- Reset clear: RESET=1 for 2 edges, then 0. Required: BUSY=1 for exactly 8 further edges, then 0. After that, reading all 8 addresses returns 8'h00.
- Write/read: write 8'h0F→r1 and 8'hF0→r2, then set OUT1ADDRESS=1, OUT2ADDRESS=2. Required: OUT1=8'h0F, OUT2=8'hF0. Both ports reading r2 return 8'hF0 on each.
- Read-during-write: r3=8'h11, then WRITE 8'hAA→r3 with OUT1ADDRESS=3. Required before the edge: OUT1=8'h11 (BYPASS=0) or 8'hAA (BYPASS=1). Required after the edge: 8'hAA in both cases.
- Write during clear: WRITE 8'h55→r7 on the cycle after RESET falls. Required: the write is ignored, and after BUSY drops r7 reads 8'h00.
- Reset mid-clear: RESET falls, 4 edges pass, RESET=1 for 1 edge, RESET falls again. Required: BUSY high for 8 more edges. A value written to r6 before the first reset reads 0 at the end.
- Reset beats write: RESET=1 and WRITE=1 (8'h77→r0) at the same edge. Required: BUSY=1, OUT1=0, and after the clear completes r0 reads 8'h00.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and default sizes for the register file and its ALU neighbour.
package reg_file_pkg;

  // Default geometry of the register file.
  localparam int unsigned DEFAULT_WIDTH    = 8;
  localparam int unsigned DEFAULT_NUM_REGS = 8;
  localparam int unsigned DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

  // Operand width shared with the ALU (DATA1/DATA2/RESULT).
  localparam int unsigned ALU_OPERAND_W = 8;

  // Clear sequencer states.
  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage : reg_file_pkg

// File: rtl/reg_file.sv
// Two-read/one-write register file with a sequenced clear after reset.
// Reads are combinational and forced to zero while the clear runs.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter bit          BYPASS   = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INADDRESS,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] OUT1ADDRESS,
  input  logic [ADDR_W-1:0] OUT2ADDRESS,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  output logic              BUSY
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(NUM_REGS - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [WIDTH-1:0]  regs_d [NUM_REGS];
  logic              wr_en;

  // A write only takes effect in READY and when reset is not overriding it.
  assign wr_en = WRITE && !RESET && (state_q == READY);
  assign BUSY  = (state_q == CLEAR);

  // Next-state logic: reset restarts the clear, CLEAR zeroes one entry per edge.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    regs_d  = regs_q;
    if (RESET) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end else begin
      case (state_q)
        CLEAR: begin
          regs_d[ptr_q] = '0;
          ptr_d         = ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_PTR) begin
            state_d = READY;
          end
        end
        READY: begin
          if (WRITE) begin
            regs_d[INADDRESS] = IN;
          end
        end
        default: begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      endcase
    end
  end

  // Sequencer state register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage array; contents are only ever zeroed by the clear sequence.
  always_ff @(posedge CLK) begin
    regs_q <= regs_d;
  end

  // Combinational read ports with optional same-cycle write forwarding.
  always_comb begin
    OUT1 = '0;
    OUT2 = '0;
    if (state_q == READY) begin
      OUT1 = regs_q[OUT1ADDRESS];
      OUT2 = regs_q[OUT2ADDRESS];
      if (BYPASS && wr_en && (OUT1ADDRESS == INADDRESS)) begin
        OUT1 = IN;
      end
      if (BYPASS && wr_en && (OUT2ADDRESS == INADDRESS)) begin
        OUT2 = IN;
      end
    end
  end

endmodule : reg_file
